// File: rtl/rv_iommu_reg_field_ctrl_if.sv
// SW register-bus handshake between the IOMMU register bus adapter (master) and the field controller (slave).
interface rv_iommu_reg_field_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 32
);
  logic          req_i;
  logic          gnt_o;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [DW/8-1:0] be_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rdata_o;
  logic          err_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, rsp_ready_i,
    output gnt_o, rsp_valid_o, rdata_o, err_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, rsp_ready_i,
    input  gnt_o, rsp_valid_o, rdata_o, err_o
  );
endinterface

// File: rtl/rv_iommu_reg_field_ctrl.sv
// IOMMU SW register bank: one access per grant, response 1 cycle later and held until accepted; HW updates merge every cycle.
// Byte-enabled writes are enabled by defining RV_IOMMU_REG_BE_EN; otherwise be_i is ignored and writes are full-width.
package rv_iommu_field_pkg;
  typedef enum logic [2:0] {
    SwAccessRW,
    SwAccessRO,
    SwAccessWO,
    SwAccessW1C,
    SwAccessW1S,
    SwAccessW0C,
    SwAccessRC
  } sw_access_e;
endpackage

module rv_iommu_reg_field_ctrl
  import rv_iommu_field_pkg::*;
#(
  parameter int         NUM_REGS = 8,
  parameter int         DW       = 32,
  parameter sw_access_e ACCESS [NUM_REGS] = '{default: SwAccessRW},
  parameter logic [DW-1:0] RESVAL [NUM_REGS] = '{default: '0}
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  rv_iommu_reg_field_ctrl_if.slave bus,
  input  logic [NUM_REGS-1:0]      hw_de_i,
  input  logic [NUM_REGS*DW-1:0]   hw_d_i,
  output logic [NUM_REGS*DW-1:0]   q_o,
  output logic [NUM_REGS-1:0]      qe_o
);

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {IDLE, RESP} state_e;

  state_e              state, state_nxt;
  logic                gnt, rsp_valid, commit, in_range;
  logic [DW-1:0]       mask;
  logic [DW-1:0]       q     [NUM_REGS];
  logic [DW-1:0]       q_nxt [NUM_REGS];
  logic [DW-1:0]       base  [NUM_REGS];
  logic [DW-1:0]       rdata_q, rdata_nxt;
  logic                err_q, err_nxt;
  logic [NUM_REGS-1:0] qe_q, qe_nxt;

  function automatic logic [DW-1:0] merge(sw_access_e acc, logic [DW-1:0] b,
                                          logic [DW-1:0] wd, logic [DW-1:0] m);
    logic [DW-1:0] r;
    r = b;
    case (acc)
      SwAccessRW, SwAccessWO: r = (b & ~m) | (wd & m);
      SwAccessW1C:            r = b & ~(wd & m);
      SwAccessW1S:            r = b | (wd & m);
      SwAccessW0C:            r = b & ~(~wd & m);
      default:                r = b;
    endcase
    return r;
  endfunction

`ifdef RV_IOMMU_REG_BE_EN
  always_comb begin
    mask = '0;
    for (int k = 0; k < DW/8; k++) begin
      mask[k*8 +: 8] = {8{bus.be_i[k]}};
    end
  end
`else
  logic unused_be;
  assign unused_be = ^bus.be_i;
  assign mask      = '1;
`endif

  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        gnt = 1'b1;
        if (bus.req_i) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign commit   = gnt & bus.req_i;
  assign in_range = 32'(bus.addr_i) < NUM_REGS;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign base[g]            = hw_de_i[g] ? hw_d_i[g*DW +: DW] : q[g];
    assign q_o[g*DW +: DW]    = q[g];
  end

  always_comb begin
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    qe_nxt    = '0;
    for (int i = 0; i < NUM_REGS; i++) q_nxt[i] = base[i];
    if (commit) begin
      rdata_nxt = '0;
      err_nxt   = ~in_range;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && in_range && 32'(bus.addr_i) == i) begin
        if (bus.we_i) begin
          q_nxt[i]  = merge(ACCESS[i], base[i], bus.wdata_i, mask);
          qe_nxt[i] = (ACCESS[i] != SwAccessRO) && (ACCESS[i] != SwAccessRC);
        end else begin
          if (ACCESS[i] != SwAccessWO) rdata_nxt = q[i];
          // A coincident HW set wins over the clear so the event is not lost.
          if (ACCESS[i] == SwAccessRC && !hw_de_i[i]) q_nxt[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      qe_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) q[i] <= RESVAL[i];
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      qe_q    <= qe_nxt;
      for (int i = 0; i < NUM_REGS; i++) q[i] <= q_nxt[i];
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign qe_o            = qe_q;

endmodule
